// File: rtl/bp_me_pkg.sv
// Shared types and helpers for the coherent accelerator complex edge block.
// Holds the lane-path state encoding and the wormhole header length decode.
package bp_me_pkg;

   typedef enum logic [1:0] {
      e_ready    = 2'd0,
      e_body     = 2'd1,
      e_isolated = 2'd2,
      e_drop     = 2'd3
   } bp_cac_edge_state_e;

   // Header is zero-extended by the caller; returns the body-flit count.
   function automatic logic [31:0] bp_cac_hdr_len(input logic [255:0] hdr_i,
                                                  input int unsigned cord_width_i,
                                                  input int unsigned len_width_i);
      logic [31:0] mask;
      mask = (32'd1 << len_width_i) - 32'd1;
      return 32'(hdr_i >> cord_width_i) & mask;
   endfunction

endpackage

// File: rtl/bp_cac_edge_lane_path.sv
// One direction of one coherence lane: small FIFO plus a packet-boundary FSM
// that either forwards, holds (isolated) or drains (inbound only) traffic.
module bp_cac_edge_lane_path
   import bp_me_pkg::*;
#(
   parameter int flit_width_p = 64,
   parameter int cord_width_p = 10,
   parameter int len_width_p  = 4,
   parameter int fifo_els_p   = 2,
   parameter int drop_en_p    = 1
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     isolate_i,
   input  logic                     v_i,
   input  logic [flit_width_p-1:0]  data_i,
   output logic                     ready_and_o,
   output logic                     v_o,
   output logic [flit_width_p-1:0]  data_o,
   input  logic                     ready_and_i,
   output bp_cac_edge_state_e       state_o,
   output logic                     hdr_drop_o
);

   localparam int ptr_w_lp = $clog2(fifo_els_p);
   localparam int cnt_w_lp = $clog2(fifo_els_p + 1);

   logic [flit_width_p-1:0] mem_q [fifo_els_p];
   logic [ptr_w_lp-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [cnt_w_lp-1:0]     count_q, count_d;
   logic                    ready_q;
   bp_cac_edge_state_e      state_q, state_d;
   logic [len_width_p-1:0]  len_cnt_q, len_cnt_d;
   logic                    enq_s, deq_s, head_v_s;
   logic [len_width_p-1:0]  hdr_len_s;

   function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_w_lp'(fifo_els_p - 1)) ? ptr_w_lp'(0) : p + ptr_w_lp'(1);
   endfunction

   assign enq_s       = v_i & ready_q;
   assign head_v_s    = (count_q != cnt_w_lp'(0));
   assign data_o      = mem_q[rd_ptr_q];
   assign hdr_len_s   = len_width_p'(bp_cac_hdr_len(256'(mem_q[rd_ptr_q]), cord_width_p, len_width_p));
   assign ready_and_o = ready_q;
   assign state_o     = state_q;

   // Packet-boundary FSM: decides forwarding, holding or draining of the head flit
   always_comb begin
      state_d    = state_q;
      len_cnt_d  = len_cnt_q;
      deq_s      = 1'b0;
      v_o        = 1'b0;
      hdr_drop_o = 1'b0;
      case (state_q)
         e_ready: begin
            if (isolate_i) begin
               state_d = e_isolated;
            end else begin
               v_o = head_v_s;
               if (head_v_s && ready_and_i) begin
                  deq_s = 1'b1;
                  if (hdr_len_s != len_width_p'(0)) begin
                     state_d   = e_body;
                     len_cnt_d = hdr_len_s;
                  end else begin
                     state_d = e_ready;
                  end
               end else begin
                  state_d = e_ready;
               end
            end
         end
         e_body: begin
            v_o = head_v_s;
            if (head_v_s && ready_and_i) begin
               deq_s     = 1'b1;
               len_cnt_d = len_cnt_q - len_width_p'(1);
               if (len_cnt_q == len_width_p'(1)) begin
                  state_d = e_ready;
               end else begin
                  state_d = e_body;
               end
            end else begin
               state_d = e_body;
            end
         end
         e_isolated: begin
            if (!isolate_i) begin
               state_d = e_ready;
            end else if ((drop_en_p != 0) && head_v_s) begin
               deq_s      = 1'b1;
               hdr_drop_o = 1'b1;
               if (hdr_len_s != len_width_p'(0)) begin
                  state_d   = e_drop;
                  len_cnt_d = hdr_len_s;
               end else begin
                  state_d = e_isolated;
               end
            end else begin
               state_d = e_isolated;
            end
         end
         e_drop: begin
            // Drain runs to completion even if isolation is withdrawn mid-packet
            if (head_v_s) begin
               deq_s     = 1'b1;
               len_cnt_d = len_cnt_q - len_width_p'(1);
               if (len_cnt_q == len_width_p'(1)) begin
                  state_d = e_isolated;
               end else begin
                  state_d = e_drop;
               end
            end else begin
               state_d = e_drop;
            end
         end
         default: begin
            state_d = e_ready;
         end
      endcase
   end

   // FIFO occupancy and pointer next-state
   always_comb begin
      rd_ptr_d = deq_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = enq_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      case ({enq_s, deq_s})
         2'b10:   count_d = count_q + cnt_w_lp'(1);
         2'b01:   count_d = count_q - cnt_w_lp'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state register; ready is registered so it is low throughout reset
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= e_ready;
         len_cnt_q <= len_width_p'(0);
         rd_ptr_q  <= ptr_w_lp'(0);
         wr_ptr_q  <= ptr_w_lp'(0);
         count_q   <= cnt_w_lp'(0);
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_cnt_q <= len_cnt_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         ready_q   <= (count_d != cnt_w_lp'(fifo_els_p));
      end
   end

   // FIFO storage
   always_ff @(posedge clk_i) begin
      if (enq_s) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/bp_cac_edge_isolator.sv
// West edge between the accelerator complex and the tile mesh: buffers every
// coherence lane in both directions and quiesces/drains rows on request.
module bp_cac_edge_isolator
   import bp_me_pkg::*;
#(
   parameter int rows_p       = 1,
   parameter int channels_p   = 3,
   parameter int flit_width_p = 64,
   parameter int cord_width_p = 10,
   parameter int len_width_p  = 4,
   parameter int fifo_els_p   = 2,
   parameter int cnt_width_p  = 16,
   localparam int link_w       = flit_width_p + 2,
   localparam int lanes        = rows_p * channels_p
) (
   input  logic                            coh_clk_i,
   input  logic                            coh_reset_i,
   input  logic [rows_p-1:0]               isolate_i,
   output logic [rows_p-1:0]               isolated_o,
   output logic [rows_p*cnt_width_p-1:0]   drop_count_o,
   input  logic [lanes*link_w-1:0]         outer_link_i,
   output logic [lanes*link_w-1:0]         outer_link_o,
   input  logic [lanes*link_w-1:0]         inner_link_i,
   output logic [lanes*link_w-1:0]         inner_link_o
);

   localparam int inc_w_lp = $clog2(2 * channels_p + 1);
   localparam int sum_w_lp = cnt_width_p + inc_w_lp;

   bp_cac_edge_state_e     ib_state_s [lanes];
   bp_cac_edge_state_e     ob_state_s [lanes];
   logic [lanes-1:0]       ib_drop_s, ob_drop_s;
   logic [cnt_width_p-1:0] drop_cnt_q [rows_p];
   logic [cnt_width_p-1:0] drop_cnt_d [rows_p];
   logic [inc_w_lp-1:0]    drop_inc_s [rows_p];
   logic [rows_p-1:0]      iso_s;

   for (genvar l = 0; l < lanes; l++) begin : g_lane
      localparam int base_lp = l * link_w;
      logic                    ib_v_s, ob_v_s, ib_ready_s, ob_ready_s;
      logic [flit_width_p-1:0] ib_data_s, ob_data_s;

      bp_cac_edge_lane_path #(
         .flit_width_p (flit_width_p),
         .cord_width_p (cord_width_p),
         .len_width_p  (len_width_p),
         .fifo_els_p   (fifo_els_p),
         .drop_en_p    (1)
      ) ib_path (
         .clk_i       (coh_clk_i),
         .reset_i     (coh_reset_i),
         .isolate_i   (isolate_i[l / channels_p]),
         .v_i         (outer_link_i[base_lp + link_w - 1]),
         .data_i      (outer_link_i[base_lp + 1 +: flit_width_p]),
         .ready_and_o (ib_ready_s),
         .v_o         (ib_v_s),
         .data_o      (ib_data_s),
         .ready_and_i (inner_link_i[base_lp]),
         .state_o     (ib_state_s[l]),
         .hdr_drop_o  (ib_drop_s[l])
      );

      bp_cac_edge_lane_path #(
         .flit_width_p (flit_width_p),
         .cord_width_p (cord_width_p),
         .len_width_p  (len_width_p),
         .fifo_els_p   (fifo_els_p),
         .drop_en_p    (0)
      ) ob_path (
         .clk_i       (coh_clk_i),
         .reset_i     (coh_reset_i),
         .isolate_i   (isolate_i[l / channels_p]),
         .v_i         (inner_link_i[base_lp + link_w - 1]),
         .data_i      (inner_link_i[base_lp + 1 +: flit_width_p]),
         .ready_and_o (ob_ready_s),
         .v_o         (ob_v_s),
         .data_o      (ob_data_s),
         .ready_and_i (outer_link_i[base_lp]),
         .state_o     (ob_state_s[l]),
         .hdr_drop_o  (ob_drop_s[l])
      );

      // Each link carries the reverse-direction ready of the opposite path
      assign outer_link_o[base_lp +: link_w] = {ob_v_s, ob_data_s, ib_ready_s};
      assign inner_link_o[base_lp +: link_w] = {ib_v_s, ib_data_s, ob_ready_s};
   end

   // Per-row quiesce status and discarded-header popcount
   always_comb begin
      for (int r = 0; r < rows_p; r++) begin
         iso_s[r]      = 1'b1;
         drop_inc_s[r] = inc_w_lp'(0);
      end
      for (int l = 0; l < lanes; l++) begin
         iso_s[l / channels_p] = iso_s[l / channels_p]
                               & (ib_state_s[l] == e_isolated)
                               & (ob_state_s[l] == e_isolated);
         drop_inc_s[l / channels_p] = drop_inc_s[l / channels_p]
                                    + inc_w_lp'(ib_drop_s[l])
                                    + inc_w_lp'(ob_drop_s[l]);
      end
   end

   // Saturating drop-counter next-state
   always_comb begin
      logic [sum_w_lp-1:0] sum_v;
      sum_v = sum_w_lp'(0);
      for (int r = 0; r < rows_p; r++) begin
         sum_v = sum_w_lp'(drop_cnt_q[r]) + sum_w_lp'(drop_inc_s[r]);
         if (sum_v > sum_w_lp'({cnt_width_p{1'b1}})) begin
            drop_cnt_d[r] = {cnt_width_p{1'b1}};
         end else begin
            drop_cnt_d[r] = sum_v[cnt_width_p-1:0];
         end
      end
   end

   // Drop-counter registers
   always_ff @(posedge coh_clk_i) begin
      for (int r = 0; r < rows_p; r++) begin
         if (coh_reset_i) begin
            drop_cnt_q[r] <= cnt_width_p'(0);
         end else begin
            drop_cnt_q[r] <= drop_cnt_d[r];
         end
      end
   end

   for (genvar r = 0; r < rows_p; r++) begin : g_row
      assign drop_count_o[r * cnt_width_p +: cnt_width_p] = drop_cnt_q[r];
   end

   assign isolated_o = iso_s;

endmodule
